// File: rtl/keyed_frame_fsm.sv
`default_nettype none
// =============================================================================
// keyed_frame_fsm : key-scheduled framed-packet receiver (sync/len/payload/chk)
// Revision 1.0
// =============================================================================
module keyed_frame_fsm #(
  parameter int                          DATA_W    = 8,
  parameter int                          KEY_W     = 7,
  parameter int                          NUM_KEYS  = 2,
  parameter int                          SLOT_LEN  = 2,
  parameter logic [NUM_KEYS*KEY_W-1:0]   KEY_VEC   = {7'd18, 7'd95},
  parameter logic [NUM_KEYS*3-1:0]       DECOY_VEC = {3'd4, 3'd5},
  parameter int                          LOCK_MODE = 0,
  parameter logic [DATA_W-1:0]           SYNC_PAT  = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [KEY_W-1:0]  keyinput,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic [2:0]        state_out,
  output logic              pay_valid,
  output logic [DATA_W-1:0] pay_data,
  output logic              frame_ok,
  output logic              frame_err
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LEN  = 3'd1;
  localparam logic [2:0] ST_PAY  = 3'd2;
  localparam logic [2:0] ST_CHK  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;
  localparam logic [2:0] ST_ERR  = 3'd5;

  localparam int SUB_W  = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
  localparam int SLOT_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam bit HOLD_ON_MISMATCH = (LOCK_MODE != 0);

  // The schedule counter is kept as (slot, cycle-within-slot) so no divider is needed.
  logic [SUB_W-1:0]  sub_q, sub_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [2:0]        state_q, state_d;
  logic [DATA_W-1:0] len_q, len_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic              pay_valid_q, pay_valid_d;
  logic [DATA_W-1:0] pay_data_q, pay_data_d;

  logic [KEY_W-1:0]  slot_key;
  logic [2:0]        slot_decoy;
  logic              key_ok;

  always_comb begin
    sub_d  = sub_q + SUB_W'(1);
    slot_d = slot_q;
    if (sub_q == SUB_W'(SLOT_LEN - 1)) begin
      sub_d  = '0;
      slot_d = (slot_q == SLOT_W'(NUM_KEYS - 1)) ? '0 : slot_q + SLOT_W'(1);
    end
  end

  always_comb begin
    slot_key   = KEY_VEC[KEY_W-1:0];
    slot_decoy = DECOY_VEC[2:0];
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (slot_q == SLOT_W'(i)) begin
        slot_key   = KEY_VEC[i*KEY_W +: KEY_W];
        slot_decoy = DECOY_VEC[i*3 +: 3];
      end
    end
  end

  assign key_ok = (keyinput == slot_key);

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    sum_d       = sum_q;
    pay_valid_d = 1'b0;
    pay_data_d  = pay_data_q;
    if (!key_ok) begin
      if (!HOLD_ON_MISMATCH) state_d = slot_decoy;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (din_valid && (din == SYNC_PAT)) state_d = ST_LEN;
        end
        ST_LEN: begin
          if (din_valid) begin
            len_d   = din;
            sum_d   = '0;
            state_d = (din == '0) ? ST_ERR : ST_PAY;
          end
        end
        ST_PAY: begin
          if (din_valid) begin
            sum_d       = sum_q + din;
            len_d       = len_q - DATA_W'(1);
            pay_valid_d = 1'b1;
            pay_data_d  = din;
            // A stale zero length (decoy entry) also ends the payload on this beat.
            if (len_q <= DATA_W'(1)) state_d = ST_CHK;
          end
        end
        ST_CHK: begin
          if (din_valid) state_d = (din == sum_q) ? ST_DONE : ST_ERR;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sub_q       <= '0;
      slot_q      <= '0;
      state_q     <= ST_IDLE;
      len_q       <= '0;
      sum_q       <= '0;
      pay_valid_q <= 1'b0;
      pay_data_q  <= '0;
    end else begin
      sub_q       <= sub_d;
      slot_q      <= slot_d;
      state_q     <= state_d;
      len_q       <= len_d;
      sum_q       <= sum_d;
      pay_valid_q <= pay_valid_d;
      pay_data_q  <= pay_data_d;
    end
  end

  assign state_out = state_q;
  assign pay_valid = pay_valid_q;
  assign pay_data  = pay_data_q;
  assign frame_ok  = (state_q == ST_DONE);
  assign frame_err = (state_q == ST_ERR);

endmodule
`default_nettype wire

// File: tb/tb_keyed_frame_fsm.sv
`default_nettype none
// tb_keyed_frame_fsm : scoreboard bench driving three parameterisations of keyed_frame_fsm
module tb_keyed_frame_fsm;

  localparam int ND = 3;
  localparam int S_IDLE = 0, S_LEN = 1, S_PAY = 2, S_CHK = 3, S_DONE = 4, S_ERR = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       din_valid;
  logic [7:0] din;
  logic [6:0] key  [ND];
  logic [2:0] so   [ND];
  logic       pv   [ND];
  logic [7:0] pd   [ND];
  logic       fok  [ND];
  logic       ferr [ND];

  keyed_frame_fsm u_dut0 (
    .clk(clk), .rst(rst_n), .keyinput(key[0]), .din(din), .din_valid(din_valid),
    .state_out(so[0]), .pay_valid(pv[0]), .pay_data(pd[0]), .frame_ok(fok[0]), .frame_err(ferr[0])
  );

  keyed_frame_fsm #(.LOCK_MODE(1)) u_dut1 (
    .clk(clk), .rst(rst_n), .keyinput(key[1]), .din(din), .din_valid(din_valid),
    .state_out(so[1]), .pay_valid(pv[1]), .pay_data(pd[1]), .frame_ok(fok[1]), .frame_err(ferr[1])
  );

  keyed_frame_fsm #(
    .NUM_KEYS(3), .SLOT_LEN(1),
    .KEY_VEC({7'd7, 7'd42, 7'd95}),
    .DECOY_VEC({3'd2, 3'd4, 3'd5})
  ) u_dut2 (
    .clk(clk), .rst(rst_n), .keyinput(key[2]), .din(din), .din_valid(din_valid),
    .state_out(so[2]), .pay_valid(pv[2]), .pay_data(pd[2]), .frame_ok(fok[2]), .frame_err(ferr[2])
  );

  // Reference parameters per instance: schedule keys and decoys listed by slot index.
  int p_mode  [ND]    = '{0, 1, 0};
  int p_nk    [ND]    = '{2, 2, 3};
  int p_sl    [ND]    = '{2, 2, 1};
  int key_tab [ND][3] = '{'{95, 18, 0}, '{95, 18, 0}, '{95, 42, 7}};
  int dec_tab [ND][3] = '{'{5, 4, 0}, '{5, 4, 0}, '{5, 4, 2}};

  int m_ctr [ND];
  int m_st  [ND];
  int m_len [ND];
  int m_sum [ND];
  int m_pv  [ND];
  int m_pd  [ND];

  typedef struct packed {
    logic [2:0] st;
    logic       pv;
    logic [7:0] pd;
  } obs_t;

  obs_t       exp_q [ND][$];
  logic [7:0] pay_q [ND][$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", nm, act, expv);
    end
  endtask

  // Frame-level behaviour for one instance across one clock edge.
  task automatic model_step(input int d, input bit rn, input logic [6:0] k, input bit v, input logic [7:0] x);
    int   slot;
    obs_t e;
    if (!rn) begin
      m_ctr[d] = 0; m_st[d] = S_IDLE; m_len[d] = 0; m_sum[d] = 0; m_pv[d] = 0; m_pd[d] = 0;
    end else begin
      slot     = m_ctr[d] / p_sl[d];
      m_ctr[d] = (m_ctr[d] + 1) % (p_nk[d] * p_sl[d]);
      m_pv[d]  = 0;
      if (int'(k) != key_tab[d][slot]) begin
        if (p_mode[d] == 0) m_st[d] = dec_tab[d][slot];
      end else begin
        case (m_st[d])
          S_IDLE: if (v && x == 8'hA5) m_st[d] = S_LEN;
          S_LEN: if (v) begin
            m_len[d] = int'(x);
            m_sum[d] = 0;
            m_st[d]  = (x == 8'd0) ? S_ERR : S_PAY;
          end
          S_PAY: if (v) begin
            m_sum[d] = (m_sum[d] + int'(x)) % 256;
            m_pv[d]  = 1;
            m_pd[d]  = int'(x);
            pay_q[d].push_back(x);
            m_st[d]  = (m_len[d] <= 1) ? S_CHK : S_PAY;
            m_len[d] = (m_len[d] + 255) % 256;
          end
          S_CHK: if (v) m_st[d] = (int'(x) == m_sum[d]) ? S_DONE : S_ERR;
          default: m_st[d] = S_IDLE;
        endcase
      end
    end
    e.st = 3'(m_st[d]);
    e.pv = (m_pv[d] != 0);
    e.pd = 8'(m_pd[d]);
    exp_q[d].push_back(e);
  endtask

  // One clock of stimulus: bad[d] forces key 0 on instance d; wrong_pct injects random bad keys.
  task automatic drive(input bit rn, input bit v, input logic [7:0] x, input logic [ND-1:0] bad, input int wrong_pct);
    int         slot;
    logic [6:0] k;
    for (int d = 0; d < ND; d++) begin
      slot = m_ctr[d] / p_sl[d];
      k    = 7'(key_tab[d][slot]);
      if (bad[d]) k = 7'd0;
      else if (int'($urandom_range(0, 99)) < wrong_pct)
        k = ($urandom_range(0, 1) == 1) ? 7'(key_tab[d][(slot + 1) % p_nk[d]]) : 7'($urandom_range(0, 127));
      key[d] = k;
      model_step(d, rn, k, v, x);
    end
    rst_n     = rn;
    din_valid = v;
    din       = x;
    @(posedge clk);
    #2;
  endtask

  task automatic send_frame(input int len, input bit corrupt, input int gap_pct, input int wrong_pct);
    logic [7:0] b [$];
    logic [7:0] p;
    int         s;
    s = 0;
    b.push_back(8'hA5);
    b.push_back(8'(len));
    for (int i = 0; i < len; i++) begin
      p = 8'($urandom_range(0, 255));
      b.push_back(p);
      s += int'(p);
    end
    b.push_back(8'(s) + (corrupt ? 8'd1 : 8'd0));
    foreach (b[i]) begin
      if (int'($urandom_range(0, 99)) < gap_pct) drive(1'b1, 1'b0, 8'($urandom_range(0, 255)), '0, wrong_pct);
      drive(1'b1, 1'b1, b[i], '0, wrong_pct);
    end
  endtask

  // Monitor: compares every presented cycle and every payload beat against the scoreboard.
  obs_t       mon_e;
  logic [7:0] mon_p;
  initial forever begin
    @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) begin
      if (exp_q[d].size() > 0) begin
        mon_e = exp_q[d].pop_front();
        n_checks++;
        if (so[d] !== mon_e.st || fok[d] !== (mon_e.st == 3'd4) || ferr[d] !== (mon_e.st == 3'd5)) begin
          n_fail++;
          $display("FAIL dut%0d state: got st=%0d ok=%0b err=%0b, want st=%0d", d, so[d], fok[d], ferr[d], mon_e.st);
        end
        n_checks++;
        if (pv[d] !== mon_e.pv || pd[d] !== mon_e.pd) begin
          n_fail++;
          $display("FAIL dut%0d pay_regs: got pv=%0b pd=%h, want pv=%0b pd=%h", d, pv[d], pd[d], mon_e.pv, mon_e.pd);
        end
        if (pv[d] === 1'b1) begin
          n_checks++;
          if (pay_q[d].size() == 0) begin
            n_fail++;
            $display("FAIL dut%0d payload_beat: got pd=%h, want no beat", d, pd[d]);
          end else begin
            mon_p = pay_q[d].pop_front();
            if (mon_p !== pd[d]) begin
              n_fail++;
              $display("FAIL dut%0d payload_beat: got pd=%h, want %h", d, pd[d], mon_p);
            end
          end
        end
      end
    end
  end

  logic [7:0] f1 [6] = '{8'hA5, 8'h03, 8'h10, 8'h20, 8'h30, 8'h60};

  initial begin
    rst_n     = 1'b0;
    din_valid = 1'b0;
    din       = 8'h00;
    for (int d = 0; d < ND; d++) key[d] = 7'd0;
    @(posedge clk);
    #2;
    drive(1'b0, 1'b0, 8'h00, '0, 0);
    drive(1'b0, 1'b0, 8'h00, '0, 0);
    check("reset_state", int'(so[0]), 0);
    check("reset_pay_valid", int'(pv[0]), 0);
    check("reset_pay_data", int'(pd[0]), 0);

    // Good frame with the correct key schedule on every instance.
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, f1[i], '0, 0);
      if (i == 4) check("t1_last_payload", int'(pd[0]), 'h30);
    end
    check("t1_frame_ok_dut0", int'(fok[0]), 1);
    check("t1_frame_ok_dut1", int'(fok[1]), 1);
    check("t1_frame_ok_dut2", int'(fok[2]), 1);
    drive(1'b1, 1'b0, 8'h00, '0, 0);
    check("t1_back_to_idle", int'(so[0]), 0);

    // Bad checksum.
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, (i == 5) ? 8'h61 : f1[i], '0, 0);
    check("t2_frame_err", int'(ferr[0]), 1);
    check("t2_no_frame_ok", int'(fok[0]), 0);
    drive(1'b1, 1'b0, 8'h00, '0, 0);
    check("t2_back_to_idle", int'(so[0]), 0);

    // Decoy jumps on dut0: slot 1 -> DONE, slot 0 -> ERR.
    drive(1'b0, 1'b0, 8'h00, '0, 0);
    drive(1'b1, 1'b1, 8'hA5, '0, 0);
    drive(1'b1, 1'b1, 8'h03, '0, 0);
    drive(1'b1, 1'b1, 8'h10, 3'b001, 0);
    check("t3_decoy_slot1_state", int'(so[0]), 4);
    check("t3_decoy_slot1_ok", int'(fok[0]), 1);
    check("t3_decoy_no_pay", int'(pv[0]), 0);
    drive(1'b1, 1'b0, 8'h00, '0, 0);
    check("t3_decoy_to_idle", int'(so[0]), 0);
    drive(1'b1, 1'b0, 8'h00, 3'b001, 0);
    check("t3_decoy_slot0_state", int'(so[0]), 5);

    // Freeze on dut1 mid-payload, then resend the dropped beats.
    drive(1'b0, 1'b0, 8'h00, '0, 0);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, f1[i], '0, 0);
    for (int i = 3; i < 6; i++) drive(1'b1, 1'b1, f1[i], 3'b010, 0);
    check("t4_frozen_state", int'(so[1]), 2);
    for (int i = 3; i < 6; i++) drive(1'b1, 1'b1, f1[i], '0, 0);
    check("t4_resume_frame_ok", int'(fok[1]), 1);
    drive(1'b1, 1'b0, 8'h00, '0, 0);

    // Reset while waiting for the checksum, then a clean frame.
    drive(1'b0, 1'b0, 8'h00, '0, 0);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, f1[i], '0, 0);
    check("t6_in_chk", int'(so[0]), 3);
    drive(1'b0, 1'b1, 8'h60, '0, 0);
    check("t6_reset_state", int'(so[0]), 0);
    check("t6_reset_pay_valid", int'(pv[0]), 0);
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, f1[i], '0, 0);
    check("t6_after_reset_ok", int'(fok[0]), 1);
    drive(1'b1, 1'b0, 8'h00, '0, 0);

    // Randomised traffic: gaps, bad/rotated keys, zero lengths, corrupt checksums, resets.
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 99) < 4) drive(1'b0, 1'b0, 8'h00, '0, 0);
      send_frame(int'($urandom_range(0, 5)), ($urandom_range(0, 4) == 0), 20, 6);
      if ($urandom_range(0, 2) == 0) drive(1'b1, 1'b0, 8'(($urandom_range(0, 1) == 1) ? 8'hA5 : 8'h00), '0, 6);
    end

    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 8'h00, '0, 0);
    for (int d = 0; d < ND; d++) check("payload_queue_drained", pay_q[d].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
